// File: rtl/pim_indirect_addr_gen.sv
// Gather-address generator: fetches an index table line by line and emits
// target_base + (index << size_shift) per element on a valid/ready stream.
module pim_indirect_addr_gen #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_x,
    input  logic [31:0]       i_args_reg_A,
    input  logic [31:0]       i_args_reg_B,
    input  logic [31:0]       i_args_reg_C,
    input  logic              i_start,
    input  logic              i_HPC_clear,
    output logic              o_rd_req_valid,
    output logic [ADDR_W-1:0] o_rd_req_addr,
    input  logic              i_rd_req_ready,
    input  logic              i_rd_rvalid,
    input  logic [DATA_W-1:0] i_rd_rdata,
    output logic              o_addr_valid,
    output logic [ADDR_W-1:0] o_addr,
    input  logic              i_addr_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [15:0]       o_emit_cnt
);

    localparam int unsigned LANES  = DATA_W / 32;
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned LINE_B = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(LINE_B);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        EMIT,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   a_q, a_d;
    logic [ADDR_W-1:0]   b_q, b_d;
    logic [15:0]         n_q, n_d;
    logic [2:0]          shift_q, shift_d;
    logic [15:0]         line_idx_q, line_idx_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [DATA_W-1:0]   line_q, line_d;
    logic [15:0]         emit_cnt_q, emit_cnt_d;
    logic [31:0]         lane_val;
    logic                unused_ok;

    assign unused_ok = ^{i_args_reg_C[31:19], i_args_reg_A[OFF_W-1:0]};

    always_ff @(posedge clk) begin
        if (rst_x) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            n_q        <= '0;
            shift_q    <= '0;
            line_idx_q <= '0;
            lane_q     <= '0;
            line_q     <= '0;
            emit_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            n_q        <= n_d;
            shift_q    <= shift_d;
            line_idx_q <= line_idx_d;
            lane_q     <= lane_d;
            line_q     <= line_d;
            emit_cnt_q <= emit_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        n_d        = n_q;
        shift_d    = shift_q;
        line_idx_d = line_idx_q;
        lane_d     = lane_q;
        line_d     = line_q;
        emit_cnt_d = emit_cnt_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    a_d        = {i_args_reg_A[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    b_d        = i_args_reg_B;
                    n_d        = i_args_reg_C[15:0];
                    shift_d    = i_args_reg_C[18:16];
                    line_idx_d = '0;
                    lane_d     = '0;
                    emit_cnt_d = '0;
                    state_d    = (i_args_reg_C[15:0] == 16'd0) ? DONE : RD_REQ;
                end
            end
            RD_REQ: begin
                if (i_rd_req_ready) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (i_rd_rvalid) begin
                    line_d  = i_rd_rdata;
                    lane_d  = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (i_addr_ready) begin
                    emit_cnt_d = emit_cnt_q + 16'd1;
                    lane_d     = lane_q + LANE_W'(1);
                    // Completion takes precedence over refilling on the last lane.
                    if (emit_cnt_q + 16'd1 == n_q) begin
                        state_d = DONE;
                    end else if (lane_q == LANE_W'(LANES - 1)) begin
                        line_idx_d = line_idx_q + 16'd1;
                        state_d    = RD_REQ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (i_HPC_clear) begin
            state_d    = IDLE;
            emit_cnt_d = '0;
        end
    end

    assign lane_val       = line_q[{lane_q, 5'd0} +: 32];
    assign o_rd_req_valid = (state_q == RD_REQ);
    assign o_rd_req_addr  = a_q + ADDR_W'(line_idx_q) * ADDR_W'(LINE_B);
    assign o_addr_valid   = (state_q == EMIT);
    assign o_addr         = b_q + ADDR_W'(lane_val << shift_q);
    assign o_busy         = (state_q == RD_REQ) || (state_q == RD_WAIT) || (state_q == EMIT);
    assign o_done         = (state_q == DONE);
    assign o_emit_cnt     = emit_cnt_q;

endmodule

// File: tb/tb_pim_indirect_addr_gen.sv
// Scoreboard bench for pim_indirect_addr_gen: a behavioural job model fills
// expected read/target queues, a negedge monitor pops and compares.
module tb_pim_indirect_addr_gen;

    logic         clk;
    logic         rst_x;
    logic [31:0]  i_args_reg_A, i_args_reg_B, i_args_reg_C;
    logic         i_start, i_HPC_clear;
    logic         o_rd_req_valid;
    logic [31:0]  o_rd_req_addr;
    logic         i_rd_req_ready;
    logic         i_rd_rvalid;
    logic [255:0] i_rd_rdata;
    logic         o_addr_valid;
    logic [31:0]  o_addr;
    logic         i_addr_ready;
    logic         o_busy, o_done;
    logic [15:0]  o_emit_cnt;

    pim_indirect_addr_gen #(.DATA_W(256), .ADDR_W(32)) dut (
        .clk(clk), .rst_x(rst_x),
        .i_args_reg_A(i_args_reg_A), .i_args_reg_B(i_args_reg_B), .i_args_reg_C(i_args_reg_C),
        .i_start(i_start), .i_HPC_clear(i_HPC_clear),
        .o_rd_req_valid(o_rd_req_valid), .o_rd_req_addr(o_rd_req_addr),
        .i_rd_req_ready(i_rd_req_ready), .i_rd_rvalid(i_rd_rvalid), .i_rd_rdata(i_rd_rdata),
        .o_addr_valid(o_addr_valid), .o_addr(o_addr), .i_addr_ready(i_addr_ready),
        .o_busy(o_busy), .o_done(o_done), .o_emit_cnt(o_emit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    bit [31:0] mem [bit [31:0]];
    bit [31:0] exp_addr [$];
    bit [31:0] exp_rd   [$];
    int unsigned job_n       = 0;
    int unsigned job_emitted = 0;
    bit rand_ready = 0;
    int resp_delay = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic bit [31:0] mem_word(input bit [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [255:0] make_line(input bit [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = mem_word(a + 32'(4*k));
        return l;
    endfunction

    // Reference: element i lives at byte (A & ~31) + 4*i; target = B + idx*2^shift mod 2^32.
    task automatic model_job(input bit [31:0] a, input bit [31:0] b, input bit [31:0] c);
        int unsigned n = c[15:0];
        int unsigned sh = c[18:16];
        bit [31:0] base = a & 32'hFFFF_FFE0;
        longint unsigned full;
        for (int unsigned l = 0; l < (n + 7) / 8; l++) exp_rd.push_back(base + 32 * l);
        for (int unsigned i = 0; i < n; i++) begin
            full = longint'(b) + longint'(mem_word(base + 4 * i)) * (64'd1 << sh);
            exp_addr.push_back(full[31:0]);
        end
        job_n = n;
        job_emitted = 0;
    endtask

    // Ready driver
    initial begin
        i_addr_ready = 1'b1;
        i_rd_req_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) begin
                i_addr_ready   = ($urandom_range(0, 3) != 0);
                i_rd_req_ready = ($urandom_range(0, 2) != 0);
            end else begin
                i_addr_ready   = 1'b1;
                i_rd_req_ready = 1'b1;
            end
        end
    end

    // Memory responder
    initial begin
        bit [31:0] ra;
        int d;
        i_rd_rvalid = 1'b0;
        i_rd_rdata  = '0;
        forever begin
            @(negedge clk);
            if (!rst_x && o_rd_req_valid && i_rd_req_ready) begin
                ra = o_rd_req_addr;
                d = (resp_delay < 0) ? int'($urandom_range(0, 2)) : resp_delay;
                @(posedge clk);
                repeat (d) @(posedge clk);
                #1;
                i_rd_rdata  = make_line(ra);
                i_rd_rvalid = 1'b1;
                @(posedge clk);
                #1;
                i_rd_rvalid = 1'b0;
            end
        end
    end

    // Monitor
    initial begin
        bit exp_done_next = 0, exp_req_next = 0;
        bit prev_astall = 0, prev_rstall = 0, prev_clr = 0;
        bit [31:0] prev_addr = 0, prev_raddr = 0, e;
        forever begin
            @(negedge clk);
            if (rst_x) begin
                exp_done_next = 0; exp_req_next = 0;
                prev_astall = 0; prev_rstall = 0; prev_clr = 0;
                continue;
            end
            if (exp_done_next) chk(o_done && !o_busy, "done_after_last", {o_done, o_busy}, 2'b10);
            if (exp_req_next) chk(o_rd_req_valid, "req_after_lane7", o_rd_req_valid, 1);
            if (prev_astall && !prev_clr)
                chk(o_addr_valid && o_addr == prev_addr, "addr_stable", o_addr, prev_addr);
            if (prev_rstall && !prev_clr)
                chk(o_rd_req_valid && o_rd_req_addr == prev_raddr, "req_stable", o_rd_req_addr, prev_raddr);
            exp_done_next = 0;
            exp_req_next = 0;
            if (o_addr_valid && i_addr_ready) begin
                if (exp_addr.size() == 0) begin
                    chk(0, "unexpected_addr", o_addr, 0);
                end else begin
                    e = exp_addr.pop_front();
                    chk(o_addr == e, "addr", o_addr, e);
                    job_emitted++;
                    if (job_emitted == job_n) exp_done_next = !i_HPC_clear;
                    else if (job_emitted % 8 == 0) exp_req_next = !i_HPC_clear;
                end
            end
            if (o_rd_req_valid && i_rd_req_ready) begin
                if (exp_rd.size() == 0) begin
                    chk(0, "unexpected_read", o_rd_req_addr, 0);
                end else begin
                    e = exp_rd.pop_front();
                    chk(o_rd_req_addr == e, "read_addr", o_rd_req_addr, e);
                end
            end
            prev_astall = o_addr_valid && !i_addr_ready;
            prev_addr   = o_addr;
            prev_rstall = o_rd_req_valid && !i_rd_req_ready;
            prev_raddr  = o_rd_req_addr;
            prev_clr    = i_HPC_clear;
        end
    end

    task automatic clear_pulse();
        @(posedge clk); #1; i_HPC_clear = 1'b1;
        @(posedge clk); #1; i_HPC_clear = 1'b0;
    endtask

    task automatic start_job(input bit [31:0] a, input bit [31:0] b, input bit [31:0] c);
        @(posedge clk); #1;
        i_args_reg_A = a; i_args_reg_B = b; i_args_reg_C = c; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_args_reg_A = $urandom; i_args_reg_B = $urandom; i_args_reg_C = $urandom;
    endtask

    task automatic run_job(input bit [31:0] a, input bit [31:0] b, input bit [31:0] c, input bit poke);
        int unsigned n = c[15:0];
        bit got = 0;
        model_job(a, b, c);
        start_job(a, b, c);
        @(negedge clk);
        if (n == 0) begin
            chk(o_done && !o_busy && !o_rd_req_valid, "zero_len_done",
                {o_done, o_busy, o_rd_req_valid}, 3'b100);
            chk(o_emit_cnt == 16'd0, "zero_len_cnt", o_emit_cnt, 0);
            @(negedge clk);
            chk(!o_done && !o_rd_req_valid, "zero_len_pulse", {o_done, o_rd_req_valid}, 0);
            return;
        end
        chk(o_busy && o_rd_req_valid, "start_latency", {o_busy, o_rd_req_valid}, 2'b11);
        if (poke) begin
            @(posedge clk); #1;
            i_start = 1'b1;
            @(posedge clk); #1;
            i_start = 1'b0;
        end
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (o_done) begin got = 1; break; end
        end
        chk(got, "done_timeout", got, 1);
        if (got) begin
            chk(o_emit_cnt == 16'(n), "emit_cnt", o_emit_cnt, n);
            chk(exp_addr.size() == 0, "addrs_left", exp_addr.size(), 0);
            chk(exp_rd.size() == 0, "reads_left", exp_rd.size(), 0);
            @(negedge clk);
            chk(!o_done && !o_busy, "done_once", {o_done, o_busy}, 0);
        end else begin
            exp_addr.delete();
            exp_rd.delete();
            clear_pulse();
        end
    endtask

    initial begin
        bit [31:0] a, b, c;
        bit bad;
        rst_x = 1'b1;
        i_start = 1'b0; i_HPC_clear = 1'b0;
        i_args_reg_A = '0; i_args_reg_B = '0; i_args_reg_C = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(!o_rd_req_valid, "rst_rd_req_valid", o_rd_req_valid, 0);
        chk(o_rd_req_addr == 0, "rst_rd_req_addr", o_rd_req_addr, 0);
        chk(!o_addr_valid, "rst_addr_valid", o_addr_valid, 0);
        chk(o_addr == 0, "rst_addr", o_addr, 0);
        chk(!o_busy, "rst_busy", o_busy, 0);
        chk(!o_done, "rst_done", o_done, 0);
        chk(o_emit_cnt == 0, "rst_emit_cnt", o_emit_cnt, 0);
        @(posedge clk); #1; rst_x = 1'b0;

        // Basic job with a start poke while busy
        mem[32'h1000] = 32'd1; mem[32'h1004] = 32'd5; mem[32'h1008] = 32'h10;
        run_job(32'h1000, 32'h8000_0000, {13'h1FFF, 3'd2, 16'd3}, 1);

        // Two lines, unaligned base
        run_job(32'h2004, 32'h0000_0100, {13'd0, 3'd0, 16'd10}, 0);

        // Wrap and dropped high bits
        mem[32'h3000] = 32'h10;
        run_job(32'h3000, 32'hFFFF_FFF0, {13'd0, 3'd1, 16'd1}, 0);
        mem[32'h3020] = 32'h0200_0000;
        run_job(32'h3020, 32'hFFFF_FFF0, {13'd0, 3'd7, 16'd1}, 0);

        // Zero length
        run_job(32'h3040, 32'h1234_0000, {13'h0ABC, 3'd5, 16'd0}, 0);

        // Clear in RD_WAIT, response lands the following cycle
        resp_delay = 1;
        exp_rd.push_back(32'h4000);
        job_n = 3; job_emitted = 0;
        start_job(32'h4000, 32'h0000_4000, 32'd3);
        @(negedge clk);
        chk(o_rd_req_valid, "clr_req", o_rd_req_valid, 1);
        clear_pulse();
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (o_addr_valid || o_done || o_busy || o_rd_req_valid) bad = 1;
        end
        chk(!bad, "clr_wait_quiet", bad, 0);
        chk(o_emit_cnt == 0, "clr_wait_cnt", o_emit_cnt, 0);
        chk(exp_rd.size() == 0, "clr_wait_read", exp_rd.size(), 0);
        resp_delay = 0;
        run_job(32'h4000, 32'h0000_4000, {13'd0, 3'd3, 16'd5}, 0);

        // Clear during EMIT
        model_job(32'h5000, 32'h0001_0000, 32'd20);
        start_job(32'h5000, 32'h0001_0000, 32'd20);
        repeat (5) @(posedge clk);
        clear_pulse();
        @(negedge clk);
        chk(!o_addr_valid && !o_busy && !o_done, "clr_emit_idle", {o_addr_valid, o_busy, o_done}, 0);
        chk(o_emit_cnt == 0, "clr_emit_cnt", o_emit_cnt, 0);
        exp_addr.delete();
        exp_rd.delete();
        repeat (4) @(negedge clk);

        // Randomized jobs with stalls
        rand_ready = 1;
        resp_delay = -1;
        for (int j = 0; j < 24; j++) begin
            a = $urandom;
            b = $urandom;
            c = $urandom;
            c[15:0] = 16'($urandom_range(0, 40));
            c[18:16] = 3'($urandom_range(0, 7));
            run_job(a, b, c, (c[15:0] != 0) && ($urandom_range(0, 1) == 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
